fifo_sync_bypass_cfg: RTL
=========================

Name: fifo_sync_bypass_cfg

Overview:
Next-generation synchronous FIFO for the cache datapath (miss/refill and write-back queues). It generalises the bypass FIFO to any depth, not just powers of two. It adds an occupancy count, programmable almost-full/almost-empty flags, synchronous flush, pass-through when full, and sticky overflow/underflow error flags. Single clock domain; storage is a 1R1W register array.

Parameters:
DEPTH, 4, number of entries; any integer 2..256.
WIDTH, 32, data width in bits; 1..512.
AFULL_TH, DEPTH-1, almostFull asserts when count >= AFULL_TH; range 1..DEPTH.
AEMPTY_TH, 1, almostEmpty asserts when count <= AEMPTY_TH; range 0..DEPTH-1.
CW, $clog2(DEPTH+1), derived width of count; not to be overridden.

Ports:
clk  input  1  clock, rising edge.
rest  input  1  reset, synchronous, active-low.
flush  input  1  synchronous clear of contents and error flags.
write  input  1  push request.
writeData  input  WIDTH  push data.
read  input  1  pop request.
readData  output  WIDTH  head data; valid when rdValid.
rdValid  output  1  readData valid this cycle.
full  output  1  count==DEPTH.
empty  output  1  count==0 (storage only; ignores bypass).
almostFull  output  1  count>=AFULL_TH.
almostEmpty  output  1  count<=AEMPTY_TH.
count  output  CW  stored entries, 0..DEPTH.
overflow  output  1  sticky: a push was dropped.
underflow  output  1  sticky: a pop hit no data.

Behaviour:
- Reset: clk and rest, one clock; reset is synchronous and active-low. Sampled at the clk edge while rest==0: front=0, rear=0, count=0, overflow=0, underflow=0. Array contents are not reset. Outputs after reset: empty=1, full=0, almostEmpty=1, almostFull=0 (AFULL_TH>=1), rdValid=0, readData=0.
- Reset mid-operation discards all entries; an in-flight write in that cycle is lost.
- Pointers: front and rear are 0..DEPTH-1 and wrap explicitly (DEPTH-1 -> 0); no extra MSB. count is a separate register.
- Priority per edge: rest > flush > read/write.
- Flush: front=rear=count=0 and overflow=underflow=0. Concurrent read/write is ignored and no error is flagged.
- Accept push: write && (!full || read). Write while full with read is a pass-through: the head pops, the new data is stored at rear, count stays DEPTH.
- Accept pop: read && count!=0.
- Count update: +1 on push only, -1 on pop only, unchanged when both.
- Data timing: stored data is visible at readData the cycle after the push edge (registered). Head read is combinational from array[front].
- readData is 0 whenever rdValid==0.
- overflow sets on write && full && !read.
- underflow sets on read && count==0 and no bypass occurs (see Optional Feature).
- All flags are combinational from count. No latency beyond the register stage.

Optional Feature:
Macro FIFO_SYNC_BYPASS_EN.
- Defined: when count==0 and write==1, readData=writeData and rdValid=1 in the same cycle. If read is also 1, the word passes through: nothing is stored, count stays 0, no underflow. If read==0, the word is stored normally.
- Undefined: rdValid = (count!=0). A read with count==0 sets underflow even if write is asserted, and the write is stored. Minimum latency is one cycle.

Decomposition:
- Package fifo_pkg:
  - function ptr_inc(ptr, depth) for the wrapping increment;
  - function clog2_cnt(depth);
  - typedef fifo_status_t packing full/empty/almostFull/almostEmpty/overflow/underflow for cache status buses.
- One sub-module, fifo_ram_1r1w (WIDTH, DEPTH): synchronous write, asynchronous read, no reset.
- Control, pointers and flags stay in fifo_sync_bypass_cfg.

Test Plan:
1. DEPTH=3, WIDTH=8: write 0x11,0x22,0x33 on consecutive cycles -> count 1,2,3. full=1 after the third; almostFull=1 from count=2; read 3 times -> 0x11,0x22,0x33; empty=1; front and rear wrap to 0.
2. Full DEPTH=3 holding A,B,C; write=1, read=1, writeData=0xD4 -> readData=A that cycle; next cycle count=3, head=B; overflow stays 0. Then write without read -> overflow=1, count=3, data dropped.
3. Bypass defined, empty: write=1, read=1, writeData=0x5A -> readData=0x5A, rdValid=1 same cycle; next cycle count=0, underflow=0. Bypass undefined, same stimulus -> rdValid=0, underflow=1, next count=1, readData=0x5A.
4. Count=2 with overflow and underflow both set; assert flush with write=1 -> next cycle count=0, empty=1, both flags 0, write ignored.
5. Count=2; drop rest for one edge while write=1 -> next cycle count=0, rdValid=0, readData=0. Resume writes and confirm order from 0 with no stale data.
6. Randomised 10k cycles, DEPTH=5, against a queue model -> readData, count and all flags match every cycle.

Source files
------------

// File: rtl/fifo_sync_bypass_cfg_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared types and helpers for the cache-datapath synchronous FIFO
// (fifo_sync_bypass_cfg) and the blocks that consume its status.
//
// Contents:
//   fifo_status_t : packed status word for cache status buses
//                   {full, empty, almostFull, almostEmpty, overflow, underflow}
//   ptr_inc()     : wrapping pointer increment for any depth (DEPTH-1 -> 0)
//   clog2_cnt()   : width of an occupancy counter that must hold 0..depth
// ---------------------------------------------------------------------------
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almostFull;
    logic almostEmpty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Depth need not be a power of two, so the wrap is an explicit compare
  // rather than a natural binary rollover.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

  // The counter must represent 'depth' itself (full), hence depth+1 values.
  function automatic int clog2_cnt(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_sync_bypass_cfg_if.sv
// ---------------------------------------------------------------------------
// fifo_sync_bypass_cfg_if
// Handshake/data bundle between a FIFO user and fifo_sync_bypass_cfg.
//
// Parameters: DEPTH (entries), WIDTH (data bits). CW is derived internally.
//
// Signals:
//   flush, write, writeData, read          : user -> FIFO
//   readData, rdValid                      : FIFO -> user, head word
//   full, empty, almostFull, almostEmpty   : FIFO -> user, occupancy flags
//   count                                  : FIFO -> user, stored entries
//   overflow, underflow                    : FIFO -> user, sticky errors
//
// Modports:
//   master : the FIFO user (drives requests)
//   slave  : the FIFO itself
// ---------------------------------------------------------------------------
interface fifo_sync_bypass_cfg_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             write;
  logic [WIDTH-1:0] writeData;
  logic             read;
  logic [WIDTH-1:0] readData;
  logic             rdValid;
  logic             full;
  logic             empty;
  logic             almostFull;
  logic             almostEmpty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, write, writeData, read,
    input  readData, rdValid, full, empty, almostFull, almostEmpty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, write, writeData, read,
    output readData, rdValid, full, empty, almostFull, almostEmpty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_sync_bypass_cfg_ram.sv
// ---------------------------------------------------------------------------
// fifo_ram_1r1w
// Storage array for fifo_sync_bypass_cfg: one synchronous write port and one
// asynchronous (combinational) read port. Contents are never reset.
//
// Parameters: WIDTH (data bits), DEPTH (entries, any value >= 2).
//
// Ports:
//   clk     : clock, rising edge
//   we_i    : write enable
//   waddr_i : write address, 0..DEPTH-1
//   wdata_i : write data
//   raddr_i : read address, 0..DEPTH-1
//   rdata_o : read data, combinational from raddr_i
// ---------------------------------------------------------------------------
module fifo_ram_1r1w #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Addresses stay within 0..DEPTH-1 because the pointers wrap explicitly.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_bypass_cfg.sv
// ---------------------------------------------------------------------------
// fifo_sync_bypass_cfg
// Synchronous FIFO for the cache datapath (miss/refill and write-back
// queues). Any depth 2..256, occupancy count, programmable almost-full /
// almost-empty thresholds, synchronous flush, pass-through when full, and
// sticky overflow/underflow flags. Single clock domain.
//
// Build option:
//   FIFO_SYNC_BYPASS_EN : when defined, a write into an empty FIFO is visible
//                         at readData in the same cycle; with a concurrent
//                         read the word passes straight through unstored.
//                         When undefined, minimum latency is one cycle.
//
// Parameters:
//   DEPTH     : entries, 2..256
//   WIDTH     : data bits, 1..512
//   AFULL_TH  : almostFull when count >= AFULL_TH (1..DEPTH)
//   AEMPTY_TH : almostEmpty when count <= AEMPTY_TH (0..DEPTH-1)
//   CW        : count width, derived; do not override
//
// Ports:
//   clk  : clock, rising edge
//   rest : synchronous reset, active-low
//   bus  : fifo_sync_bypass_cfg_if.slave (requests, head data, flags, count)
// ---------------------------------------------------------------------------
module fifo_sync_bypass_cfg
  import fifo_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 32,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1,
  parameter int CW        = clog2_cnt(DEPTH)
) (
  input logic                 clk,
  input logic                 rest,
  fifo_sync_bypass_cfg_if.slave bus
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  logic [PW-1:0]    front_q, front_d;
  logic [PW-1:0]    rear_q,  rear_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q,   ovf_d;
  logic             udf_q,   udf_d;

  logic [WIDTH-1:0] head;
  logic             is_full;
  logic             is_empty;
  logic             byp;
  logic             push;
  logic             pop;
  logic             ram_we;
  fifo_status_t     status;

  assign is_full  = (count_q == DEPTH_C);
  assign is_empty = (count_q == '0);

`ifdef FIFO_SYNC_BYPASS_EN
  // Word written into an empty FIFO is presented at the output immediately.
  assign byp = is_empty && bus.write;
`else
  assign byp = 1'b0;
`endif

  assign pop = bus.read && !is_empty;

  // Full + read + write is a pass-through: the head leaves as the new word
  // lands in the slot it vacates. A bypassed word consumed in the same
  // cycle is never stored.
  assign push = bus.write && (!is_full || bus.read) && !(byp && bus.read);

  always_comb begin
    front_d = front_q;
    rear_d  = rear_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (bus.flush) begin
      front_d = '0;
      rear_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (push) begin
        rear_d = PW'(ptr_inc(int'(rear_q), DEPTH));
      end
      if (pop) begin
        front_d = PW'(ptr_inc(int'(front_q), DEPTH));
      end
      case ({push, pop})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
      if (bus.write && is_full && !bus.read) begin
        ovf_d = 1'b1;
      end
      if (bus.read && is_empty && !byp) begin
        udf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rest) begin
      front_q <= '0;
      rear_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      front_q <= front_d;
      rear_q  <= rear_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Reset and flush both win over a concurrent write, so the array must not
  // capture it either.
  assign ram_we = push && rest && !bus.flush;

  fifo_ram_1r1w #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (rear_q),
    .wdata_i (bus.writeData),
    .raddr_i (front_q),
    .rdata_o (head)
  );

  // Stored head takes precedence; otherwise the bypassed word, otherwise 0.
  assign bus.readData = !is_empty ? head :
                        (byp ? bus.writeData : '0);
  assign bus.rdValid  = !is_empty || byp;

  assign status.full        = is_full;
  assign status.empty       = is_empty;
  assign status.almostFull  = (count_q >= AFULL_C);
  assign status.almostEmpty = (count_q <= AEMPTY_C);
  assign status.overflow    = ovf_q;
  assign status.underflow   = udf_q;

  assign bus.full        = status.full;
  assign bus.empty       = status.empty;
  assign bus.almostFull  = status.almostFull;
  assign bus.almostEmpty = status.almostEmpty;
  assign bus.overflow    = status.overflow;
  assign bus.underflow   = status.underflow;
  assign bus.count       = count_q;

endmodule
